sha1_pad: RTL and testbench



---
 rtl/sha1_pad.sv | 164 ++++++++++++++++
 tb/tb_sha1_pad.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_pad.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha1_pad : FIPS 180-4 message padding ahead of the SHA-1 compute core.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sha1_pad (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         out_last,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_OUT   = 2'd1,
    S_EXTRA = 2'd2
  } state_t;

  state_t             state_q;
  logic [15:0][31:0]  buf_q;
  logic [3:0]         w_q;
  logic [63:0]        len_q;
  logic               pend_q;
  logic               xpad_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic               busy_q;
  logic               err_q;

  logic [2:0]         b_d;
  logic [63:0]        len_d;
  logic [31:0]        mask_d;
  logic [31:0]        padw_d;
  logic [31:0]        dword_d;
  logic [4:0]         p_d;
  logic [15:0][31:0]  fin_d;
  logic [15:0][31:0]  extra_d;

  assign in_ready  = (state_q == S_FILL) && !reset;
  assign out_valid = out_valid_q;
  assign out_block = buf_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err       = err_q;

  // Final-word block: earlier words, masked data plus 0x80 marker, zero fill,
  // and the length in words 14/15 when it still fits (pad index <= 13).
  always_comb begin
    b_d   = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    len_d = len_q + {58'd0, b_d, 3'b000};
    case (b_d)
      3'd0:    mask_d = 32'h0000_0000;
      3'd1:    mask_d = 32'hFF00_0000;
      3'd2:    mask_d = 32'hFFFF_0000;
      3'd3:    mask_d = 32'hFFFF_FF00;
      default: mask_d = 32'hFFFF_FFFF;
    endcase
    padw_d  = (b_d == 3'd4) ? 32'h0 : (32'h8000_0000 >> {b_d, 3'b000});
    dword_d = (in_data & mask_d) | padw_d;
    p_d     = {1'b0, w_q} + ((b_d == 3'd4) ? 5'd1 : 5'd0);
    fin_d   = '0;
    for (int k = 0; k < 16; k++) begin
      if (5'(k) < {1'b0, w_q})       fin_d[k] = buf_q[k];
      else if (5'(k) == {1'b0, w_q}) fin_d[k] = dword_d;
      else if (5'(k) == p_d)         fin_d[k] = 32'h8000_0000;
      else                           fin_d[k] = 32'h0;
    end
    if (p_d <= 5'd13) begin
      fin_d[14] = len_d[63:32];
      fin_d[15] = len_d[31:0];
    end
    extra_d     = '0;
    extra_d[0]  = xpad_q ? 32'h8000_0000 : 32'h0;
    extra_d[14] = len_q[63:32];
    extra_d[15] = len_q[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILL;
      buf_q       <= '0;
      w_q         <= 4'd0;
      len_q       <= 64'd0;
      pend_q      <= 1'b0;
      xpad_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (in_valid) begin
            if (in_last) begin
              buf_q       <= fin_d;
              len_q       <= len_d;
              w_q         <= 4'd0;
              busy_q      <= 1'b1;
              state_q     <= S_OUT;
              out_valid_q <= 1'b1;
              out_last_q  <= (p_d <= 5'd13);
              pend_q      <= (p_d > 5'd13);
              xpad_q      <= (p_d == 5'd16);
            end else if (in_bytes < 3'd4) begin
              err_q <= 1'b1;
            end else begin
              buf_q[w_q] <= in_data;
              len_q      <= len_d;
              busy_q     <= 1'b1;
              w_q        <= w_q + 4'd1;
              if (w_q == 4'd15) begin
                state_q     <= S_OUT;
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
              end
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (pend_q) begin
              buf_q      <= extra_d;
              state_q    <= S_EXTRA;
              out_last_q <= 1'b1;
            end else begin
              state_q     <= S_FILL;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              w_q         <= 4'd0;
              if (out_last_q) begin
                len_q  <= 64'd0;
                busy_q <= 1'b0;
              end
            end
          end
        end
        S_EXTRA: begin
          if (out_ready) begin
            state_q     <= S_FILL;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            w_q         <= 4'd0;
            len_q       <= 64'd0;
            pend_q      <= 1'b0;
            xpad_q      <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha1_pad.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sha1_pad : directed-vector bench for the SHA-1 padding front end.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_sha1_pad;

  typedef logic [15:0][31:0] blk_t;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  b;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w15;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [2:0]   in_bytes = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [511:0] out_block;
  logic         out_last;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;

  sha1_pad dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_blk(input string nm, input blk_t got, input blk_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      for (int k = 0; k < 16; k++) begin
        if (got[k] !== exp[k]) begin
          $display("FAIL %s word %0d: got %h want %h", nm, k, got[k], exp[k]);
          break;
        end
      end
    end
  endtask

  function automatic logic [31:0] dw(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  task automatic send(input logic [31:0] d, input logic [2:0] b, input logic l);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = b;
    in_last  = l;
    @(posedge clk);
  endtask

  task automatic send_msg(input int n, input logic [2:0] lb, input logic [31:0] ld);
    for (int i = 0; i < n - 1; i++) send(dw(i), 3'd4, 1'b0);
    send(ld, lb, 1'b1);
  endtask

  // Waits (bounded) for out_valid, checks latency, then takes the block.
  task automatic get_block(input string nm, input int exp_lat, output blk_t blk, output logic lst);
    int n;
    n = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(exp_lat));
    blk = out_block;
    lst = out_last;
    out_ready = 1'b1;
    @(posedge clk);
  endtask

  vec_t tv[5];
  blk_t blk, exp, snap;
  logic lst;

  initial begin
    tv[0] = '{32'hDEAD_BEEF, 3'd0, 32'h8000_0000, 32'h0,         32'h0000_0000};
    tv[1] = '{32'h61FF_FFFF, 3'd1, 32'h6180_0000, 32'h0,         32'h0000_0008};
    tv[2] = '{32'h6162_FFFF, 3'd2, 32'h6162_8000, 32'h0,         32'h0000_0010};
    tv[3] = '{32'h6162_6300, 3'd3, 32'h6162_6380, 32'h0,         32'h0000_0018};
    tv[4] = '{32'h6162_6364, 3'd4, 32'h6162_6364, 32'h8000_0000, 32'h0000_0020};

    repeat (3) @(negedge clk);
    chk("rst in_ready",  {63'd0, in_ready},  64'd0);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst out_last",  {63'd0, out_last},  64'd0);
    chk("rst busy",      {63'd0, busy},      64'd0);
    chk("rst err",       {63'd0, err},       64'd0);
    chk_blk("rst out_block", out_block, '0);
    reset = 1'b0;

    // Single-word messages of 0..4 bytes.
    for (int i = 0; i < 5; i++) begin
      send(tv[i].d, tv[i].b, 1'b1);
      get_block($sformatf("vec%0d", i), 0, blk, lst);
      exp = '0;
      exp[0]  = tv[i].w0;
      exp[1]  = tv[i].w1;
      exp[15] = tv[i].w15;
      chk_blk($sformatf("vec%0d block", i), blk, exp);
      chk($sformatf("vec%0d last", i), {63'd0, lst}, 64'd1);
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("vec%0d busy", i), {63'd0, busy}, 64'd0);
    end

    // 55 bytes: marker lands in word 13, length still fits.
    send_msg(14, 3'd3, dw(13));
    get_block("m55", 0, blk, lst);
    exp = '0;
    for (int k = 0; k < 13; k++) exp[k] = dw(k);
    exp[13] = 32'hA000_0080;
    exp[15] = 32'h0000_01B8;
    chk_blk("m55 block", blk, exp);
    chk("m55 last", {63'd0, lst}, 64'd1);

    // 56 bytes: pad in word 14, length spills into a second block.
    send_msg(14, 3'd4, dw(13));
    get_block("m56 b1", 0, blk, lst);
    exp = '0;
    for (int k = 0; k < 14; k++) exp[k] = dw(k);
    exp[14] = 32'h8000_0000;
    chk_blk("m56 b1 block", blk, exp);
    chk("m56 b1 last", {63'd0, lst}, 64'd0);
    get_block("m56 b2", 0, blk, lst);
    exp = '0;
    exp[15] = 32'h0000_01C0;
    chk_blk("m56 b2 block", blk, exp);
    chk("m56 b2 last", {63'd0, lst}, 64'd1);

    // 60 bytes: pad in word 15.
    send_msg(15, 3'd4, dw(14));
    get_block("m60 b1", 0, blk, lst);
    exp = '0;
    for (int k = 0; k < 15; k++) exp[k] = dw(k);
    exp[15] = 32'h8000_0000;
    chk_blk("m60 b1 block", blk, exp);
    chk("m60 b1 last", {63'd0, lst}, 64'd0);
    get_block("m60 b2", 0, blk, lst);
    exp = '0;
    exp[15] = 32'h0000_01E0;
    chk_blk("m60 b2 block", blk, exp);
    chk("m60 b2 last", {63'd0, lst}, 64'd1);

    // 64 bytes with 5 cycles of backpressure; input offered meanwhile is ignored.
    send_msg(16, 3'd4, dw(15));
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    in_bytes  = 3'd4;
    in_last   = 1'b1;
    out_ready = 1'b0;
    chk("m64 valid", {63'd0, out_valid}, 64'd1);
    snap = out_block;
    exp = '0;
    for (int k = 0; k < 16; k++) exp[k] = dw(k);
    chk_blk("m64 b1 block", snap, exp);
    chk("m64 b1 last", {63'd0, out_last}, 64'd0);
    chk("m64 busy", {63'd0, busy}, 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_blk("bp stable", out_block, snap);
      chk("bp last",     {63'd0, out_last},  64'd0);
      chk("bp valid",    {63'd0, out_valid}, 64'd1);
      chk("bp in_ready", {63'd0, in_ready},  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    get_block("m64 b2", 0, blk, lst);
    exp = '0;
    exp[0]  = 32'h8000_0000;
    exp[15] = 32'h0000_0200;
    chk_blk("m64 b2 block", blk, exp);
    chk("m64 b2 last", {63'd0, lst}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("m64 idle valid", {63'd0, out_valid}, 64'd0);
    chk("m64 idle busy",  {63'd0, busy},      64'd0);

    // Protocol error: short non-last word is dropped and flagged.
    send(dw(0), 3'd4, 1'b0);
    send(dw(1), 3'd4, 1'b0);
    send(32'hFFFF_FFFF, 3'd2, 1'b0);
    send(32'h6162_6300, 3'd3, 1'b1);
    get_block("perr", 0, blk, lst);
    exp = '0;
    exp[0]  = dw(0);
    exp[1]  = dw(1);
    exp[2]  = 32'h6162_6380;
    exp[15] = 32'h0000_0058;
    chk_blk("perr block", blk, exp);
    chk("perr last", {63'd0, lst}, 64'd1);
    chk("perr err",  {63'd0, err}, 64'd1);

    // Reset after 7 words: nothing emitted, next message is clean.
    for (int i = 0; i < 7; i++) send(dw(i), 3'd4, 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("mid busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst in_ready", {63'd0, in_ready}, 64'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mrst out_valid", {63'd0, out_valid}, 64'd0);
    end
    chk("mrst busy", {63'd0, busy}, 64'd0);
    chk("mrst err",  {63'd0, err},  64'd0);
    send(32'h6162_6300, 3'd3, 1'b1);
    get_block("abc2", 0, blk, lst);
    exp = '0;
    exp[0]  = 32'h6162_6380;
    exp[15] = 32'h0000_0018;
    chk_blk("abc2 block", blk, exp);
    chk("abc2 last", {63'd0, lst}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
